// File: rtl/enigma_feeder_if.sv
// Host symbol stream into the Enigma feeder (valid/ready).
//   s_valid : host symbol valid           s_ready : feeder can accept
//   s_data  : rotor entry / message code  s_mode  : crypt mode (first rotor symbol)
//   s_last  : last message symbol, also terminates an errored job
interface enigma_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [5:0] s_data;
  logic       s_mode;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_mode, output s_last,
                  input  s_ready);
  modport slave  (input  s_valid, input  s_data, input  s_mode, input  s_last,
                  output s_ready);
endinterface

// File: rtl/enigma_feeder.sv
// Enigma feeder: buffers two 64-entry rotor tables plus a message from the
// host, checks both tables are permutations, then replays them to the core
// as 128 contiguous in_valid cycles, a gap, n contiguous in_valid_2 cycles
// and a drain period.
//   clk, rst_n   : clock, asynchronous active-low reset
//   host         : symbol stream (slave side of enigma_feeder_if)
//   in_valid     : rotor-table valid to the core
//   in_valid_2   : message valid to the core
//   crypt_mode   : latched mode, first in_valid cycle only
//   code_in      : symbol to the core, 0 when neither valid is high
//   busy, done, err : job in progress / completion pulse / bad rotor table
module enigma_feeder #(
  parameter int unsigned MSG_MAX = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  enigma_feeder_if.slave  host,
  output logic            in_valid,
  output logic            in_valid_2,
  output logic            crypt_mode,
  output logic [5:0]      code_in,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned SYM_W  = 6;
  localparam int unsigned ROT_N  = 128;
  localparam int unsigned ROT_W  = 7;
  localparam int unsigned LEN_W  = $clog2(MSG_MAX + 1);
  localparam int unsigned MSG_AW = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
  localparam int unsigned CNT_W  = (LEN_W > 8) ? LEN_W : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_ROT, S_PLAY_ROT, S_LD_MSG, S_PLAY_MSG, S_DRAIN, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [ROT_W-1:0]   rot_idx_q, rot_idx_d;
  logic [LEN_W-1:0]   msg_idx_q, msg_idx_d;
  logic [LEN_W-1:0]   msg_len_q, msg_len_d;
  logic [CNT_W-1:0]   pc_q, pc_d;
  logic [63:0]        seen_a_q, seen_a_d;
  logic [63:0]        seen_b_q, seen_b_d;
  logic               mode_q, mode_d;

  logic               s_ready_q, s_ready_d;
  logic               in_valid_q, in_valid_d;
  logic               in_valid_2_q, in_valid_2_d;
  logic               crypt_mode_q, crypt_mode_d;
  logic [SYM_W-1:0]   code_in_q, code_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               rot_we, msg_we;
  logic [ROT_W-1:0]   rot_waddr;
  logic [MSG_AW-1:0]  msg_waddr;
  logic               accept, dup;

  logic [SYM_W-1:0]   rot_mem [ROT_N];
  logic [SYM_W-1:0]   msg_mem [MSG_MAX];

  assign accept = host.s_valid && s_ready_q;
  // Bit 6 of the rotor index selects table B.
  assign dup    = rot_idx_q[6] ? seen_b_q[host.s_data] : seen_a_q[host.s_data];

  // Symbol buffers; never reset, contents are always rewritten before replay.
  always_ff @(posedge clk) begin
    if (rot_we) rot_mem[rot_waddr] <= host.s_data;
    if (msg_we) msg_mem[msg_waddr] <= host.s_data;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rot_idx_q    <= '0;
      msg_idx_q    <= '0;
      msg_len_q    <= '0;
      pc_q         <= '0;
      seen_a_q     <= '0;
      seen_b_q     <= '0;
      mode_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      in_valid_q   <= 1'b0;
      in_valid_2_q <= 1'b0;
      crypt_mode_q <= 1'b0;
      code_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rot_idx_q    <= rot_idx_d;
      msg_idx_q    <= msg_idx_d;
      msg_len_q    <= msg_len_d;
      pc_q         <= pc_d;
      seen_a_q     <= seen_a_d;
      seen_b_q     <= seen_b_d;
      mode_q       <= mode_d;
      s_ready_q    <= s_ready_d;
      in_valid_q   <= in_valid_d;
      in_valid_2_q <= in_valid_2_d;
      crypt_mode_q <= crypt_mode_d;
      code_in_q    <= code_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next state, buffer writes and next output values.
  always_comb begin
    state_d      = state_q;
    rot_idx_d    = rot_idx_q;
    msg_idx_d    = msg_idx_q;
    msg_len_d    = msg_len_q;
    pc_d         = pc_q;
    seen_a_d     = seen_a_q;
    seen_b_d     = seen_b_q;
    mode_d       = mode_q;
    rot_we       = 1'b0;
    rot_waddr    = rot_idx_q;
    msg_we       = 1'b0;
    msg_waddr    = MSG_AW'(msg_idx_q);
    in_valid_d   = 1'b0;
    in_valid_2_d = 1'b0;
    crypt_mode_d = 1'b0;
    code_in_d    = '0;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rot_we                 = 1'b1;
          rot_waddr              = '0;
          seen_a_d[host.s_data]  = 1'b1;
          mode_d                 = host.s_mode;
          rot_idx_d              = ROT_W'(1);
          state_d                = S_LD_ROT;
        end
      end
      S_LD_ROT: begin
        if (accept) begin
          if (dup) begin
            // s_last on the offending symbol closes the error immediately.
            state_d = host.s_last ? S_IDLE : S_ERR;
          end else begin
            rot_we = 1'b1;
            if (rot_idx_q[6]) seen_b_d[host.s_data] = 1'b1;
            else              seen_a_d[host.s_data] = 1'b1;
            if (rot_idx_q == ROT_W'(ROT_N - 1)) begin
              pc_d    = '0;
              state_d = S_PLAY_ROT;
            end else begin
              rot_idx_d = rot_idx_q + ROT_W'(1);
            end
          end
        end
      end
      S_PLAY_ROT: begin
        // pc runs 0..127 driving the table; the extra cycle at 128 hands over.
        if (pc_q == CNT_W'(ROT_N)) begin
          msg_idx_d = '0;
          state_d   = S_LD_MSG;
        end else begin
          in_valid_d   = 1'b1;
          code_in_d    = rot_mem[pc_q[ROT_W-1:0]];
          crypt_mode_d = mode_q && (pc_q == '0);
          pc_d         = pc_q + CNT_W'(1);
        end
      end
      S_LD_MSG: begin
        if (accept) begin
          msg_we = 1'b1;
          if (host.s_last || (msg_idx_q == LEN_W'(MSG_MAX - 1))) begin
            msg_len_d = msg_idx_q + LEN_W'(1);
            pc_d      = '0;
            state_d   = S_PLAY_MSG;
          end else begin
            msg_idx_d = msg_idx_q + LEN_W'(1);
          end
        end
      end
      S_PLAY_MSG: begin
        if (pc_q == CNT_W'(msg_len_q)) begin
          pc_d    = '0;
          state_d = S_DRAIN;
        end else begin
          in_valid_2_d = 1'b1;
          code_in_d    = msg_mem[MSG_AW'(pc_q)];
          pc_d         = pc_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Together with the hand-over cycle this gives done three edges
        // after the last in_valid_2 edge.
        if (pc_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          pc_d = pc_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        if (accept && host.s_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every return to IDLE starts the next job from a clean slate.
    if (state_d == S_IDLE) begin
      rot_idx_d = '0;
      msg_idx_d = '0;
      pc_d      = '0;
      seen_a_d  = '0;
      seen_b_d  = '0;
      mode_d    = 1'b0;
    end

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LD_ROT) ||
                (state_d == S_LD_MSG) || (state_d == S_ERR);
    err_d     = (state_d == S_ERR);
    busy_d    = (state_d != S_IDLE);
  end

  assign host.s_ready = s_ready_q;
  assign in_valid     = in_valid_q;
  assign in_valid_2   = in_valid_2_q;
  assign crypt_mode   = crypt_mode_q;
  assign code_in      = code_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_enigma_feeder.sv
// Bench for enigma_feeder: directed and randomized jobs, per-cycle trace
// compared against an expected timeline built from accept edges.
module tb_enigma_feeder;
  localparam int unsigned MSG_MAX = 64;
  localparam int NC = 16384;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enigma_feeder_if hif ();
  logic       in_valid, in_valid_2, crypt_mode, busy, done, err;
  logic [5:0] code_in;

  enigma_feeder #(.MSG_MAX(MSG_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (hif.slave),
    .in_valid   (in_valid),
    .in_valid_2 (in_valid_2),
    .crypt_mode (crypt_mode),
    .code_in    (code_in),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Trace of outputs as seen after edge number cyc.
  logic       r_rdy [NC];
  logic       r_iv  [NC];
  logic       r_iv2 [NC];
  logic       r_cm  [NC];
  logic       r_dn  [NC];
  logic       r_bz  [NC];
  logic       r_er  [NC];
  logic [5:0] r_code[NC];
  always @(negedge clk) begin
    if (cyc < NC) begin
      r_rdy[cyc]  <= hif.s_ready;
      r_iv[cyc]   <= in_valid;
      r_iv2[cyc]  <= in_valid_2;
      r_cm[cyc]   <= crypt_mode;
      r_dn[cyc]   <= done;
      r_bz[cyc]   <= busy;
      r_er[cyc]   <= err;
      r_code[cyc] <= code_in;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [5:0] rot_m [128];
  logic [5:0] msg_m [$];

  // Offer one symbol after 'gap' idle cycles; returns the accepting edge.
  task automatic put(input logic [5:0] d, input logic md, input logic lst,
                     input int gap, output int acc);
    logic rdy;
    hif.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    hif.s_valid = 1'b1;
    hif.s_data  = d;
    hif.s_mode  = md;
    hif.s_last  = lst;
    acc = -1;
    for (int t = 0; t < 600 && acc < 0; t++) begin
      rdy = hif.s_ready;
      @(posedge clk); #1;
      if (rdy) acc = cyc;
    end
    hif.s_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Expected timeline: f first accept, k 128th rotor accept, m last msg accept.
  task automatic check_job(input int f, input int k, input int m, input int n,
                           input logic mode);
    logic e_iv, e_iv2, e_cm, e_dn, e_rdy, e_bz;
    logic [5:0] e_code;
    for (int c = f; c <= m + n + 3; c++) begin
      e_iv   = (c >= k + 1) && (c <= k + 128);
      e_iv2  = (c >= m + 1) && (c <= m + n);
      e_cm   = (c == k + 1) ? mode : 1'b0;
      e_dn   = (c == m + n + 3);
      e_rdy  = (c < k) || ((c >= k + 129) && (c < m)) || (c == m + n + 3);
      e_bz   = (c < m + n + 3);
      e_code = e_iv ? rot_m[c - k - 1] : (e_iv2 ? msg_m[c - m - 1] : 6'd0);
      chk($sformatf("in_valid@%0d", c),   32'(r_iv[c]),   32'(e_iv));
      chk($sformatf("in_valid_2@%0d", c), 32'(r_iv2[c]),  32'(e_iv2));
      chk($sformatf("crypt_mode@%0d", c), 32'(r_cm[c]),   32'(e_cm));
      chk($sformatf("code_in@%0d", c),    32'(r_code[c]), 32'(e_code));
      chk($sformatf("done@%0d", c),       32'(r_dn[c]),   32'(e_dn));
      chk($sformatf("s_ready@%0d", c),    32'(r_rdy[c]),  32'(e_rdy));
      chk($sformatf("busy@%0d", c),       32'(r_bz[c]),   32'(e_bz));
      chk($sformatf("err@%0d", c),        32'(r_er[c]),   32'd0);
    end
  endtask

  task automatic run_job(input logic mode, input int gmin, input int gmax,
                         input bit use_last);
    int f, k, m, acc, n;
    f = 0; k = 0; m = 0;
    n = msg_m.size();
    for (int i = 0; i < 128; i++) begin
      // s_mode after the first symbol and s_last during rotors are noise.
      put(rot_m[i], (i == 0) ? mode : 1'($urandom), 1'($urandom),
          int'($urandom_range(gmax, gmin)), acc);
      if (i == 0)   f = acc;
      if (i == 127) k = acc;
    end
    for (int j = 0; j < n; j++) begin
      put(msg_m[j], 1'($urandom), use_last && (j == n - 1),
          int'($urandom_range(gmax, gmin)), acc);
      m = acc;
    end
    repeat (n + 6) @(posedge clk);
    #1;
    check_job(f, k, m, n, mode);
  endtask

  task automatic set_identity();
    for (int i = 0; i < 128; i++) rot_m[i] = 6'(i % 64);
  endtask

  task automatic set_random_perms();
    logic [5:0] t;
    int j;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) rot_m[b*64 + i] = 6'(i);
      for (int i = 63; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = rot_m[b*64 + i];
        rot_m[b*64 + i] = rot_m[b*64 + j];
        rot_m[b*64 + j] = t;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"},    32'(hif.s_ready), 32'd0);
    chk({tag, "_in_valid"},   32'(in_valid),    32'd0);
    chk({tag, "_in_valid_2"}, 32'(in_valid_2),  32'd0);
    chk({tag, "_crypt_mode"}, 32'(crypt_mode),  32'd0);
    chk({tag, "_code_in"},    32'(code_in),     32'd0);
    chk({tag, "_busy"},       32'(busy),        32'd0);
    chk({tag, "_done"},       32'(done),        32'd0);
    chk({tag, "_err"},        32'(err),         32'd0);
  endtask

  initial begin
    int f, d, e, k, acc, n;
    hif.s_valid = 1'b0;
    hif.s_data  = '0;
    hif.s_mode  = 1'b0;
    hif.s_last  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(hif.s_ready), 32'd1);

    // Identity tables, encrypt, message 0,1,2.
    set_identity();
    msg_m = {6'd0, 6'd1, 6'd2};
    run_job(1'b0, 0, 0, 1'b1);

    // Random permutations, decrypt, host valid every other cycle.
    set_random_perms();
    msg_m.delete();
    for (int j = 0; j < 5; j++) msg_m.push_back(6'($urandom));
    run_job(1'b1, 1, 1, 1'b1);

    // Rotor-A entry 10 duplicates value 5.
    set_identity();
    rot_m[10] = 6'd5;
    f = 0; d = 0;
    for (int i = 0; i <= 10; i++) begin
      put(rot_m[i], 1'b0, 1'b0, 0, acc);
      if (i == 0)  f = acc;
      if (i == 10) d = acc;
    end
    for (int j = 0; j < 3; j++) put(6'($urandom), 1'b0, 1'b0, int'($urandom_range(1, 0)), acc);
    put(6'($urandom), 1'b0, 1'b1, 0, e);
    repeat (4) @(posedge clk);
    #1;
    for (int c = f; c <= e + 3; c++) begin
      chk($sformatf("err_in_valid@%0d", c),   32'(r_iv[c]),   32'd0);
      chk($sformatf("err_in_valid_2@%0d", c), 32'(r_iv2[c]),  32'd0);
      chk($sformatf("err_code_in@%0d", c),    32'(r_code[c]), 32'd0);
      chk($sformatf("err_done@%0d", c),       32'(r_dn[c]),   32'd0);
      chk($sformatf("err_s_ready@%0d", c),    32'(r_rdy[c]),  32'd1);
      chk($sformatf("err_err@%0d", c),        32'(r_er[c]),   32'((c >= d) && (c < e)));
    end
    chk("err_busy_idle", 32'(r_bz[e + 1]), 32'd0);

    // Full-length message without s_last: forced termination.
    set_random_perms();
    msg_m.delete();
    for (int j = 0; j < int'(MSG_MAX); j++) msg_m.push_back(6'($urandom));
    run_job(1'($urandom), 0, 2, 1'b0);

    // One-symbol message 63.
    set_random_perms();
    msg_m = {6'd63};
    run_job(1'b0, 0, 1, 1'b1);

    // Reset during rotor playback cycle 50.
    set_identity();
    k = 0;
    for (int i = 0; i < 128; i++) begin
      put(rot_m[i], 1'b1, 1'b0, 0, acc);
      if (i == 127) k = acc;
    end
    repeat (50) @(posedge clk);
    #1;
    chk("pre_reset_in_valid", 32'(in_valid), 32'd1);
    chk("pre_reset_code_in",  32'(code_in),  32'd49);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", 32'(hif.s_ready), 32'd1);
    msg_m = {6'd0, 6'd1, 6'd2};
    run_job(1'b0, 0, 0, 1'b1);

    // Randomized jobs.
    for (int r = 0; r < 2; r++) begin
      set_random_perms();
      msg_m.delete();
      n = int'($urandom_range(MSG_MAX, 1));
      for (int j = 0; j < n; j++) msg_m.push_back(6'($urandom));
      run_job(1'($urandom), 0, 1, (n < int'(MSG_MAX)) ? 1'b1 : 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
